screen_fader: RTL and testbench

//  Drives the palette brightness input. It ramps an 8-bit brightness toward a CPU-programmed target, one step per N frames, synced to the VGA frame-start pulse.
//  It sits between the VGA timing generator and the palette stage, and is memory-mapped on the system bus.

---
 rtl/gpu_pkg.sv | 14 +
 rtl/fade_step.sv | 26 ++
 rtl/screen_fader.sv | 140 ++++++++++++++
 tb/tb_screen_fader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared gpu definitions: fader register indices and fader FSM state encoding.
package gpu_pkg;

    localparam logic [1:0] FADE_TARGET = 2'd0;
    localparam logic [1:0] FADE_CONFIG = 2'd1;
    localparam logic [1:0] FADE_STATUS = 2'd2;
    localparam logic [1:0] FADE_BRIGHT = 2'd3;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        FADING = 1'b1
    } fade_state_e;

endpackage

// File: rtl/fade_step.sv
// One saturating brightness step toward the target; never overshoots and never wraps.
module fade_step (
    input  logic [7:0] cur,
    input  logic [7:0] tgt,
    input  logic [7:0] step,
    output logic [7:0] nxt
);

    logic [8:0] s9;
    logic [8:0] sum;
    logic [8:0] diff;

    always_comb begin
        s9   = (step == 8'd0) ? 9'd1 : {1'b0, step};
        sum  = {1'b0, cur} + s9;
        diff = {1'b0, cur} - s9;
        nxt  = tgt;
        if (cur < tgt) begin
            if (sum < {1'b0, tgt}) nxt = sum[7:0];
        end else begin
            // diff[8] set means the subtraction went below zero
            if (!diff[8] && (diff > {1'b0, tgt})) nxt = diff[7:0];
        end
    end

endmodule

// File: rtl/screen_fader.sv
// Frame-synchronous brightness fader for the palette stage, memory-mapped on the system bus.
module screen_fader
    import gpu_pkg::*;
#(
    parameter int RATE_W  = 8,
    parameter int RST_BRT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        memenable,
    input  logic [1:0]  memaddr,
    input  logic        memwrite,
    input  logic [15:0] writedata,
    output logic [15:0] memdata,
    output logic [7:0]  brightness,
    output logic        fading,
    output logic        done_irq
);

    fade_state_e       state_q, state_d;
    logic [7:0]        brightness_q, brightness_d;
    logic [7:0]        target_q, target_d;
    logic [7:0]        step_q, step_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              irq_q, irq_d;
    logic [15:0]       memdata_q, memdata_d;

    logic              wr;
    logic              rd;
    logic [RATE_W:0]   cnt_inc;
    logic [RATE_W:0]   rate_eff;
    logic [7:0]        step_next;

    assign wr       = memenable & memwrite;
    assign rd       = memenable & ~memwrite;
    assign cnt_inc  = {1'b0, cnt_q} + (RATE_W+1)'(1);
    assign rate_eff = (rate_q == '0) ? (RATE_W+1)'(1) : {1'b0, rate_q};

    fade_step u_fade_step (
        .cur  (brightness_q),
        .tgt  (target_q),
        .step (step_q),
        .nxt  (step_next)
    );

    always_comb begin
        state_d      = state_q;
        brightness_d = brightness_q;
        target_d     = target_q;
        step_d       = step_q;
        rate_d       = rate_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        irq_d        = 1'b0;
        memdata_d    = memdata_q;

        // A bus write owns the cycle; a coincident frame_start is dropped.
        if (wr) begin
            case (memaddr)
                FADE_TARGET: begin
                    target_d = writedata[7:0];
                    cnt_d    = '0;
                    state_d  = FADING;
                end
                FADE_CONFIG: begin
                    step_d = writedata[15:8];
                    rate_d = writedata[RATE_W-1:0];
                end
                FADE_STATUS: begin
                    if (writedata[9]) done_d = 1'b0;
                end
                FADE_BRIGHT: begin
                    brightness_d = writedata[7:0];
                    cnt_d        = '0;
                    state_d      = IDLE;
                end
            endcase
        end else if (state_q == FADING) begin
            if (brightness_q == target_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
                irq_d   = 1'b1;
            end else if (frame_start) begin
                if (cnt_inc >= rate_eff) begin
                    cnt_d        = '0;
                    brightness_d = step_next;
                    if (step_next == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc[RATE_W-1:0];
                end
            end
        end

        if (rd) begin
            case (memaddr)
                FADE_TARGET: memdata_d = {8'h00, target_q};
                FADE_CONFIG: memdata_d = {step_q, 8'(rate_q)};
                FADE_STATUS: memdata_d = {6'b0, done_q, (state_q == FADING), brightness_q};
                FADE_BRIGHT: memdata_d = {8'h00, brightness_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            brightness_q <= 8'(RST_BRT);
            target_q     <= 8'(RST_BRT);
            step_q       <= 8'd8;
            rate_q       <= RATE_W'(1);
            cnt_q        <= '0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
            memdata_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            brightness_q <= brightness_d;
            target_q     <= target_d;
            step_q       <= step_d;
            rate_q       <= rate_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            irq_q        <= irq_d;
            memdata_q    <= memdata_d;
        end
    end

    assign memdata    = memdata_q;
    assign brightness = brightness_q;
    assign fading     = (state_q == FADING);
    assign done_irq   = irq_q;

endmodule

// File: tb/tb_screen_fader.sv
// Directed bench for screen_fader: register access, fades, abort, bus/frame collisions and async reset.
module tb_screen_fader;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        memenable;
    logic [1:0]  memaddr;
    logic        memwrite;
    logic [15:0] writedata;
    logic [15:0] memdata;
    logic [7:0]  brightness;
    logic        fading;
    logic        done_irq;

    int tests = 0;
    int fails = 0;
    int irq_cnt = 0;

    screen_fader #(.RATE_W(8), .RST_BRT(255)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .memenable   (memenable),
        .memaddr     (memaddr),
        .memwrite    (memwrite),
        .writedata   (writedata),
        .memdata     (memdata),
        .brightness  (brightness),
        .fading      (fading),
        .done_irq    (done_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done_irq === 1'b1) irq_cnt++;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [15:0] d, input logic with_frame);
        memenable = 1'b1; memwrite = 1'b1; memaddr = a; writedata = d; frame_start = with_frame;
        @(posedge clk); #1;
        memenable = 1'b0; memwrite = 1'b0; frame_start = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
        memenable = 1'b1; memwrite = 1'b0; memaddr = a;
        @(posedge clk); #1;
        memenable = 1'b0;
        d = memdata;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset_n = 1'b1; frame_start = 1'b0; memenable = 1'b0; memwrite = 1'b0;
        memaddr = 2'd0; writedata = 16'h0000;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (brightness !== 8'd255) begin fails++; $display("FAIL reset_brightness: got %0d expected 255", brightness); end
        tests++; if (fading !== 1'b0) begin fails++; $display("FAIL reset_fading: got %b expected 0", fading); end
        tests++; if (done_irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", done_irq); end
        tests++; if (memdata !== 16'h0000) begin fails++; $display("FAIL reset_memdata: got %h expected 0000", memdata); end
        reset_n = 1'b1;
        idle(1);
        read_reg(FADE_STATUS, d);
        tests++; if (d !== 16'h00FF) begin fails++; $display("FAIL reset_status: got %h expected 00ff", d); end
        tests++; if (done_irq !== 1'b0 || fading !== 1'b0) begin fails++; $display("FAIL reset_flags: got irq=%b fading=%b expected 0 0", done_irq, fading); end
    endtask

    task automatic test_fade_down();
        logic [7:0]  exp [4] = '{8'd191, 8'd127, 8'd63, 8'd0};
        logic [15:0] d;
        int base;
        write_reg(FADE_CONFIG, 16'h4001, 1'b0);
        write_reg(FADE_TARGET, 16'h0000, 1'b0);
        tests++; if (fading !== 1'b1) begin fails++; $display("FAIL down_fading: got %b expected 1", fading); end
        idle(3);
        tests++; if (brightness !== 8'd255) begin fails++; $display("FAIL down_hold: got %0d expected 255", brightness); end
        base = irq_cnt;
        for (int i = 0; i < 4; i++) begin
            frame();
            tests++; if (brightness !== exp[i]) begin fails++; $display("FAIL down_step%0d: got %0d expected %0d", i, brightness, exp[i]); end
        end
        tests++; if (done_irq !== 1'b1 || fading !== 1'b0) begin fails++; $display("FAIL down_end: got irq=%b fading=%b expected 1 0", done_irq, fading); end
        idle(2);
        tests++; if (irq_cnt - base !== 1) begin fails++; $display("FAIL down_irq_count: got %0d expected 1", irq_cnt - base); end
        read_reg(FADE_STATUS, d);
        tests++; if (d !== 16'h0200) begin fails++; $display("FAIL down_status: got %h expected 0200", d); end
    endtask

    task automatic test_fade_up();
        logic [7:0]  exp [3] = '{8'd15, 8'd25, 8'd30};
        logic [7:0]  prev;
        logic [15:0] d;
        int base;
        write_reg(FADE_STATUS, 16'h0200, 1'b0);
        read_reg(FADE_STATUS, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL up_done_clear: got %h expected 0000", d); end
        write_reg(FADE_CONFIG, 16'h0A03, 1'b0);
        read_reg(FADE_CONFIG, d);
        tests++; if (d !== 16'h0A03) begin fails++; $display("FAIL up_config_read: got %h expected 0a03", d); end
        write_reg(FADE_BRIGHT, 16'h0005, 1'b0);
        tests++; if (brightness !== 8'd5) begin fails++; $display("FAIL up_bright: got %0d expected 5", brightness); end
        write_reg(FADE_TARGET, 16'h001E, 1'b0);
        base = irq_cnt;
        prev = 8'd5;
        for (int i = 0; i < 3; i++) begin
            frame();
            frame();
            tests++; if (brightness !== prev) begin fails++; $display("FAIL up_wait%0d: got %0d expected %0d", i, brightness, prev); end
            frame();
            tests++; if (brightness !== exp[i]) begin fails++; $display("FAIL up_step%0d: got %0d expected %0d", i, brightness, exp[i]); end
            prev = exp[i];
        end
        tests++; if (done_irq !== 1'b1) begin fails++; $display("FAIL up_irq: got %b expected 1", done_irq); end
        idle(2);
        tests++; if (irq_cnt - base !== 1) begin fails++; $display("FAIL up_irq_count: got %0d expected 1", irq_cnt - base); end
        read_reg(FADE_STATUS, d);
        tests++; if (d !== 16'h021E) begin fails++; $display("FAIL up_status: got %h expected 021e", d); end
    endtask

    task automatic test_abort();
        logic [15:0] d;
        int base;
        write_reg(FADE_CONFIG, 16'h0101, 1'b0);
        write_reg(FADE_TARGET, 16'h00C8, 1'b0);
        frame();
        tests++; if (brightness !== 8'd31 || fading !== 1'b1) begin fails++; $display("FAIL abort_pre: got %0d/%b expected 31/1", brightness, fading); end
        base = irq_cnt;
        write_reg(FADE_BRIGHT, 16'h0064, 1'b0);
        tests++; if (brightness !== 8'd100 || fading !== 1'b0) begin fails++; $display("FAIL abort_now: got %0d/%b expected 100/0", brightness, fading); end
        frame();
        tests++; if (brightness !== 8'd100) begin fails++; $display("FAIL abort_frame: got %0d expected 100", brightness); end
        idle(2);
        tests++; if (irq_cnt - base !== 0) begin fails++; $display("FAIL abort_irq: got %0d expected 0", irq_cnt - base); end
        read_reg(FADE_STATUS, d);
        tests++; if (d !== 16'h0264) begin fails++; $display("FAIL abort_status: got %h expected 0264", d); end
    endtask

    task automatic test_back_to_back();
        write_reg(FADE_CONFIG, 16'h0A02, 1'b0);
        write_reg(FADE_TARGET, 16'h0096, 1'b1);
        tests++; if (brightness !== 8'd100 || fading !== 1'b1) begin fails++; $display("FAIL coinc_target: got %0d/%b expected 100/1", brightness, fading); end
        frame();
        tests++; if (brightness !== 8'd100) begin fails++; $display("FAIL coinc_first: got %0d expected 100", brightness); end
        frame();
        tests++; if (brightness !== 8'd110) begin fails++; $display("FAIL coinc_second: got %0d expected 110", brightness); end
        frame();
        write_reg(FADE_CONFIG, 16'h0A02, 1'b1);
        tests++; if (brightness !== 8'd110) begin fails++; $display("FAIL coinc_config: got %0d expected 110", brightness); end
        frame();
        tests++; if (brightness !== 8'd120) begin fails++; $display("FAIL coinc_after: got %0d expected 120", brightness); end
        write_reg(FADE_TARGET, 16'h0078, 1'b0);
        tests++; if (fading !== 1'b1 || done_irq !== 1'b0) begin fails++; $display("FAIL equal_write: got fading=%b irq=%b expected 1 0", fading, done_irq); end
        idle(1);
        tests++; if (done_irq !== 1'b1 || fading !== 1'b0) begin fails++; $display("FAIL equal_done: got irq=%b fading=%b expected 1 0", done_irq, fading); end
        idle(1);
        tests++; if (done_irq !== 1'b0) begin fails++; $display("FAIL equal_pulse: got %b expected 0", done_irq); end
    endtask

    task automatic test_async_reset();
        logic [15:0] d;
        write_reg(FADE_CONFIG, 16'h0101, 1'b0);
        write_reg(FADE_TARGET, 16'h0000, 1'b0);
        frame();
        tests++; if (brightness !== 8'd119 || fading !== 1'b1) begin fails++; $display("FAIL areset_pre: got %0d/%b expected 119/1", brightness, fading); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (brightness !== 8'd255 || fading !== 1'b0 || done_irq !== 1'b0) begin fails++; $display("FAIL areset_now: got %0d/%b/%b expected 255/0/0", brightness, fading, done_irq); end
        #3 reset_n = 1'b1;
        idle(1);
        read_reg(FADE_STATUS, d);
        tests++; if (d !== 16'h00FF) begin fails++; $display("FAIL areset_status: got %h expected 00ff", d); end
        read_reg(FADE_CONFIG, d);
        tests++; if (d !== 16'h0801) begin fails++; $display("FAIL areset_config: got %h expected 0801", d); end
        read_reg(FADE_TARGET, d);
        tests++; if (d !== 16'h00FF) begin fails++; $display("FAIL areset_target: got %h expected 00ff", d); end
        write_reg(FADE_TARGET, 16'h00FF, 1'b0);
        idle(2);
        read_reg(FADE_STATUS, d);
        tests++; if (d !== 16'h02FF) begin fails++; $display("FAIL done_set: got %h expected 02ff", d); end
        write_reg(FADE_STATUS, 16'h0200, 1'b0);
        read_reg(FADE_STATUS, d);
        tests++; if (d !== 16'h00FF) begin fails++; $display("FAIL done_clear: got %h expected 00ff", d); end
    endtask

    initial begin
        test_reset();
        test_fade_down();
        test_fade_up();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
